emit_stream_arbiter: RTL and testbench
======================================

Name: emit_stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares one downstream emit buffer stream among NUM_PORTS requesters; typically placed in front of the emit block's s_inbuf interface.
- A grant is held from the first beat to the tlast beat of a packet, so beats from different requesters never interleave.
- Output passes through one registered pipeline stage; AXI-stream handshake on all sides.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..16).
- BUF_DATA_WIDTH, 256, tdata width per port, in bits.
- BUF_KEEP_WIDTH, BUF_DATA_WIDTH/8, tkeep width per port.
- ID_WIDTH, $clog2(NUM_PORTS), width of the port index.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_buf_axis_tdata  in  NUM_PORTS*BUF_DATA_WIDTH  packed per-port data; port i occupies [i*BUF_DATA_WIDTH +: BUF_DATA_WIDTH].
- s_buf_axis_tkeep  in  NUM_PORTS*BUF_KEEP_WIDTH  packed per-port keep.
- s_buf_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_buf_axis_tready  out  NUM_PORTS  per-port ready.
- s_buf_axis_tlast  in  NUM_PORTS  per-port last.
- m_outbuf_axis_tdata  out  BUF_DATA_WIDTH  arbitrated data.
- m_outbuf_axis_tkeep  out  BUF_KEEP_WIDTH  arbitrated keep.
- m_outbuf_axis_tvalid  out  1  output valid.
- m_outbuf_axis_tready  in  1  downstream ready.
- m_outbuf_axis_tlast  out  1  output last.
- busy  out  1  high while a packet is granted or still held in the output stage.

Behaviour:
- States are ARB (no grant) and XFER (grant held). The registers are state, grant_id[ID_WIDTH], rr_ptr[ID_WIDTH] and the output stage (data/keep/last/valid).
- Reset:
  - state=ARB, rr_ptr=0, grant_id=0.
  - m_outbuf_axis_tvalid=0; tdata, tkeep and tlast =0.
  - s_buf_axis_tready=0, busy=0.
  - Reset mid-packet discards the partial packet and the output-stage contents; no tlast is emitted for it.
- ARB state:
  - All s_buf_axis_tready=0.
  - If any tvalid is high, select the first valid port found searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - Register that port as grant_id and move to XFER on the next edge.
  - Arbitration costs exactly 1 bubble cycle per packet.
- XFER state:
  - s_buf_axis_tready[grant_id] = (!m_outbuf_axis_tvalid || m_outbuf_axis_tready). All other readies are 0.
  - On an accepted beat, the output stage loads that beat's data/keep/last, and m_outbuf_axis_tvalid=1 on the next cycle. Input-to-output latency is 1 cycle.
  - On an accepted beat with tlast=1: rr_ptr <= grant_id+1 (wraps to 0 after NUM_PORTS-1), and the state returns to ARB.
- Output stage:
  - Holds its contents while tvalid && !tready.
  - Clears tvalid on a downstream handshake when no new beat is loaded in the same cycle.
  - Simultaneous drain and load give full throughput of 1 beat/cycle inside a packet.
- Beats with tkeep==0 are forwarded unchanged. tkeep is never modified or checked by this block.
- A granted port whose tvalid drops mid-packet keeps the grant; no other port is served until its tlast.
- Single-beat packets (tlast on the first beat) are legal and take 2 cycles per packet: ARB plus XFER.
- busy = (state==XFER) || m_outbuf_axis_tvalid.
- Fairness: with all ports continuously requesting, grants follow 0,1,2,...,NUM_PORTS-1,0,...

Optional Feature:
- Macro: EMIT_ARB_TID_EN.
- With the macro defined:
  - Adds output port m_outbuf_axis_tid [ID_WIDTH], the source port index, registered alongside tdata.
  - Its value is valid whenever m_outbuf_axis_tvalid=1 and it resets to 0.
- Without the macro, the port and its register are absent and all other behaviour is identical.

Test Plan:
- Reset then idle: all tvalid=0 for 10 cycles -> all readies 0, m_outbuf_axis_tvalid=0, busy=0.
- Fairness: NUM_PORTS=4, all ports send continuous 3-beat packets, sink always ready -> output packet order is 0,1,2,3,0,1; each packet takes 4 cycles (1 bubble + 3 beats); no interleaving.
- Backpressure: port 2 sends a 5-beat packet with tdata=beat index; sink ready toggles 1,0,1,0 -> output beats are 0..4 in order, none duplicated or lost, and tdata/tkeep/tlast stay stable while stalled.
- Pointer wrap and non-interleave: port 3 sends a packet while port 1 raises tvalid mid-packet -> port 1 is granted only after port 3's tlast beat; the next search starts at port 0, and port 0 is idle, so port 1 wins.
- Reset mid-packet: assert rst on beat 2 of a 4-beat packet from port 0 -> the next cycle shows tvalid=0, state=ARB, rr_ptr=0; a fresh packet from port 1 is then forwarded intact.
- EMIT_ARB_TID_EN defined: one single-beat packet each from ports 1 and 3 -> m_outbuf_axis_tid reads 1, then 3, and each packet's tlast=1.

Source files
------------

// File: rtl/emit_stream_arbiter.sv
// Packet round-robin arbiter onto one emit buffer stream; EMIT_ARB_TID_EN adds m_outbuf_axis_tid.
// Latency: one arbitration bubble per packet, then 1 cycle from accepted input beat to output.
// Backpressure: only the granted port sees tready, high while the output stage is empty or draining.
module emit_stream_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int BUF_DATA_WIDTH = 256,
    parameter int BUF_KEEP_WIDTH = BUF_DATA_WIDTH / 8,
    parameter int ID_WIDTH       = $clog2(NUM_PORTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS*BUF_DATA_WIDTH-1:0] s_buf_axis_tdata,
    input  logic [NUM_PORTS*BUF_KEEP_WIDTH-1:0] s_buf_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                s_buf_axis_tvalid,
    output logic [NUM_PORTS-1:0]                s_buf_axis_tready,
    input  logic [NUM_PORTS-1:0]                s_buf_axis_tlast,
    output logic [BUF_DATA_WIDTH-1:0]           m_outbuf_axis_tdata,
    output logic [BUF_KEEP_WIDTH-1:0]           m_outbuf_axis_tkeep,
    output logic                                m_outbuf_axis_tvalid,
    input  logic                                m_outbuf_axis_tready,
    output logic                                m_outbuf_axis_tlast,
`ifdef EMIT_ARB_TID_EN
    output logic [ID_WIDTH-1:0]                 m_outbuf_axis_tid,
`endif
    output logic                                busy
);

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_t;

    typedef struct packed {
        logic [BUF_DATA_WIDTH-1:0] tdata;
        logic [BUF_KEEP_WIDTH-1:0] tkeep;
        logic                      tlast;
    } beat_t;

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_PORTS - 1);

    state_t              state;
    logic [ID_WIDTH-1:0] grant_id;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] sel_id;
    logic                sel_vld;
    int                  scan_idx;
    beat_t               in_beat;
    beat_t               out_beat;
    logic                out_vld;
    logic                load_rdy;
    logic                beat_acc;
`ifdef EMIT_ARB_TID_EN
    logic [ID_WIDTH-1:0] out_tid;
`endif

    // Scan from the highest offset down so the port nearest rr_ptr is the last writer and wins.
    always_comb begin
        sel_vld  = 1'b0;
        sel_id   = '0;
        scan_idx = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= NUM_PORTS) begin
                scan_idx = scan_idx - NUM_PORTS;
            end
            if (s_buf_axis_tvalid[scan_idx]) begin
                sel_vld = 1'b1;
                sel_id  = ID_WIDTH'(scan_idx);
            end
        end
    end

    always_comb begin
        in_beat.tdata = s_buf_axis_tdata[int'(grant_id)*BUF_DATA_WIDTH +: BUF_DATA_WIDTH];
        in_beat.tkeep = s_buf_axis_tkeep[int'(grant_id)*BUF_KEEP_WIDTH +: BUF_KEEP_WIDTH];
        in_beat.tlast = s_buf_axis_tlast[grant_id];
    end

    assign load_rdy = !out_vld || m_outbuf_axis_tready;
    assign beat_acc = (state == XFER) && load_rdy && s_buf_axis_tvalid[grant_id];

    always_comb begin
        s_buf_axis_tready = '0;
        if (state == XFER && load_rdy) begin
            s_buf_axis_tready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            grant_id <= '0;
            rr_ptr   <= '0;
            out_vld  <= 1'b0;
            out_beat <= '0;
`ifdef EMIT_ARB_TID_EN
            out_tid  <= '0;
`endif
        end else begin
            // Load and drain in the same cycle keeps one beat per cycle inside a packet.
            if (beat_acc) begin
                out_beat <= in_beat;
                out_vld  <= 1'b1;
`ifdef EMIT_ARB_TID_EN
                out_tid  <= grant_id;
`endif
            end else if (m_outbuf_axis_tready) begin
                out_vld <= 1'b0;
            end

            case (state)
                ARB: begin
                    if (sel_vld) begin
                        grant_id <= sel_id;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (beat_acc && in_beat.tlast) begin
                        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_WIDTH'(1);
                        state  <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    assign m_outbuf_axis_tdata  = out_beat.tdata;
    assign m_outbuf_axis_tkeep  = out_beat.tkeep;
    assign m_outbuf_axis_tlast  = out_beat.tlast;
    assign m_outbuf_axis_tvalid = out_vld;
`ifdef EMIT_ARB_TID_EN
    assign m_outbuf_axis_tid    = out_tid;
`endif
    assign busy = (state == XFER) || out_vld;

endmodule

// File: tb/tb_emit_stream_arbiter.sv
// Bench for emit_stream_arbiter: directed scenarios plus randomized traffic against a packet-queue model.
module tb_emit_stream_arbiter;
    localparam int N  = 4;
    localparam int DW = 256;
    localparam int KW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] s_tdata  = '0;
    logic [N*KW-1:0] s_tkeep  = '0;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tready;
    logic [N-1:0]    s_tlast  = '0;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic            m_tlast;
    logic            busy;
`ifdef EMIT_ARB_TID_EN
    logic [IW-1:0]   m_tid;
`endif

    emit_stream_arbiter #(
        .NUM_PORTS(N), .BUF_DATA_WIDTH(DW), .BUF_KEEP_WIDTH(KW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_buf_axis_tdata(s_tdata), .s_buf_axis_tkeep(s_tkeep),
        .s_buf_axis_tvalid(s_tvalid), .s_buf_axis_tready(s_tready),
        .s_buf_axis_tlast(s_tlast),
        .m_outbuf_axis_tdata(m_tdata), .m_outbuf_axis_tkeep(m_tkeep),
        .m_outbuf_axis_tvalid(m_tvalid), .m_outbuf_axis_tready(m_tready),
        .m_outbuf_axis_tlast(m_tlast),
`ifdef EMIT_ARB_TID_EN
        .m_outbuf_axis_tid(m_tid),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t src_q[N][$];
    beat_t exp_q[N][$];
    int    start_cyc[N];
    int    ord_q[$];
    int    cyc_q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    pkt_seq = 0;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // idx_mode: tdata is the beat index and tkeep all ones; otherwise random payload tagged with port/sequence.
    task automatic add_pkt(input int p, input int len, input bit idx_mode);
        beat_t bt;
        for (int b = 0; b < len; b++) begin
            bt = '0;
            if (idx_mode) begin
                bt.d = DW'(b);
                bt.k = '1;
            end else begin
                for (int w = 0; w < DW / 32; w++) bt.d[w*32 +: 32] = $urandom;
                bt.d[15:0] = {8'(p), 8'(pkt_seq)};
                bt.k = $urandom;
                if ($urandom_range(7) == 0) bt.k = '0;
            end
            bt.l = (b == len - 1);
            src_q[p].push_back(bt);
            exp_q[p].push_back(bt);
        end
        pkt_seq++;
    endtask

    // rdy_mode: 0 always ready, 1 toggles 1,0,1,0..., 2 random.
    task automatic run_traffic(input int max_cyc, input int vld_pct, input int rdy_mode);
        bit    acc[N];
        bit    in_pkt, prev_stall, done, have;
        beat_t prev_beat, ob;
        int    cur_port, remain;
        in_pkt = 0; prev_stall = 0; done = 0; cur_port = -1; remain = 0;
        prev_beat = '0;
        ord_q.delete();
        cyc_q.delete();
        for (int p = 0; p < N; p++) acc[p] = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            for (int p = 0; p < N; p++) begin
                if (acc[p]) void'(src_q[p].pop_front());
                acc[p] = 0;
            end
            ob = {m_tdata, m_tkeep, m_tlast};
            if (prev_stall) begin
                check("stall_hold_vld", 320'(m_tvalid), 320'(1));
                check("stall_hold_beat", 320'(ob), 320'(prev_beat));
            end
            remain = 0;
            for (int p = 0; p < N; p++) remain += src_q[p].size() + exp_q[p].size();
            if (remain == 0) begin
                done = 1;
            end else begin
                for (int p = 0; p < N; p++) begin
                    if (src_q[p].size() > 0 && i >= start_cyc[p] &&
                        int'($urandom_range(99)) < vld_pct) begin
                        s_tvalid[p]           = 1'b1;
                        s_tdata[p*DW +: DW]   = src_q[p][0].d;
                        s_tkeep[p*KW +: KW]   = src_q[p][0].k;
                        s_tlast[p]            = src_q[p][0].l;
                    end else begin
                        s_tvalid[p]           = 1'b0;
                        s_tdata[p*DW +: DW]   = '0;
                        s_tkeep[p*KW +: KW]   = '0;
                        s_tlast[p]            = 1'b0;
                    end
                end
                case (rdy_mode)
                    0:       m_tready = 1'b1;
                    1:       m_tready = (i % 2 == 0);
                    default: m_tready = ($urandom_range(9) < 7);
                endcase
                #1;
                check("rdy_onehot0", 320'($countones(s_tready) <= 1), 320'(1));
                if (m_tvalid && !m_tready) check("rdy_when_stalled", 320'(s_tready), 320'(0));
                if (m_tvalid) check("busy_with_vld", 320'(busy), 320'(1));
                for (int p = 0; p < N; p++) acc[p] = s_tvalid[p] && s_tready[p];
                if (m_tvalid && m_tready) begin
                    ob = {m_tdata, m_tkeep, m_tlast};
                    if (!in_pkt) begin
                        cur_port = -1;
                        for (int p = N - 1; p >= 0; p--)
                            if (exp_q[p].size() > 0 && exp_q[p][0] === ob) cur_port = p;
                        check("pkt_src_found", 320'(cur_port >= 0), 320'(1));
                        if (cur_port >= 0) ord_q.push_back(cur_port);
                    end
                    cyc_q.push_back(i);
                    have = 0;
                    if (cur_port >= 0) have = exp_q[cur_port].size() > 0;
                    check("beat_has_source", 320'(have), 320'(1));
                    if (have) begin
                        check("beat", 320'(ob), 320'(exp_q[cur_port][0]));
`ifdef EMIT_ARB_TID_EN
                        check("tid", 320'(m_tid), 320'(cur_port));
`endif
                        void'(exp_q[cur_port].pop_front());
                    end
                    in_pkt = !m_tlast;
                end
                prev_stall = m_tvalid && !m_tready;
                prev_beat  = {m_tdata, m_tkeep, m_tlast};
            end
        end
        check("drained", 320'(remain), 320'(0));
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
        m_tready = 1'b1;
        for (int p = 0; p < N; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
            start_cyc[p] = 0;
        end
    endtask

    initial begin
        for (int p = 0; p < N; p++) start_cyc[p] = 0;

        // Reset then idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tdata", 320'(m_tdata), 320'(0));
        check("rst_tkeep_tlast", 320'({m_tkeep, m_tlast}), 320'(0));
`ifdef EMIT_ARB_TID_EN
        check("rst_tid", 320'(m_tid), 320'(0));
`endif
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_rdy_vld_busy", 320'({s_tready, m_tvalid, busy}), 320'(0));
        end

        // Fairness with 3-beat packets: order 0..3 twice, 4 cycles per packet
        for (int k = 0; k < 2; k++) for (int p = 0; p < N; p++) add_pkt(p, 3, 0);
        run_traffic(200, 100, 0);
        check("fair_npkts", 320'(ord_q.size()), 320'(8));
        foreach (ord_q[n]) check("fair_order", 320'(ord_q[n]), 320'(n % N));
        check("fair_nbeats", 320'(cyc_q.size()), 320'(24));
        foreach (cyc_q[n]) check("fair_cycle", 320'(cyc_q[n]), 320'((n / 3) * 4 + n % 3 + 2));

        // Single-beat packets: 2 cycles per packet
        for (int p = 0; p < N; p++) add_pkt(p, 1, 0);
        run_traffic(100, 100, 0);
        foreach (ord_q[n]) check("single_order", 320'(ord_q[n]), 320'(n));
        foreach (cyc_q[n]) check("single_cycle", 320'(cyc_q[n]), 320'(2 * n + 2));

        // Backpressure: 5-beat packet of beat indices, sink toggling
        add_pkt(2, 5, 1);
        run_traffic(200, 100, 1);
        check("bp_npkts", 320'(ord_q.size()), 320'(1));
        check("bp_port", 320'(ord_q[0]), 320'(2));
        check("bp_nbeats", 320'(cyc_q.size()), 320'(5));

        // Non-interleave and wrap: port 1 requests mid-packet of port 3
        add_pkt(3, 3, 0);
        add_pkt(1, 2, 0);
        start_cyc[1] = 2;
        run_traffic(100, 100, 0);
        check("wrap_npkts", 320'(ord_q.size()), 320'(2));
        check("wrap_first", 320'(ord_q[0]), 320'(3));
        check("wrap_second", 320'(ord_q[1]), 320'(1));

        // Reset mid-packet from port 0; rr pointer must return to 0
        @(negedge clk);
        m_tready = 1'b1;
        s_tvalid = 4'b0001;
        s_tdata[0 +: DW] = DW'(32'ha0);
        s_tkeep[0 +: KW] = '1;
        s_tlast = '0;
        @(negedge clk);
        @(negedge clk);
        s_tdata[0 +: DW] = DW'(32'ha1);
        @(negedge clk);
        check("pre_rst_vld", 320'(m_tvalid), 320'(1));
        s_tdata[0 +: DW] = DW'(32'ha2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = '0;
        s_tdata = '0;
        s_tkeep = '0;
        #1;
        check("mid_rst_vld", 320'(m_tvalid), 320'(0));
        check("mid_rst_busy_rdy", 320'({busy, s_tready}), 320'(0));
        check("mid_rst_tlast", 320'(m_tlast), 320'(0));
        add_pkt(1, 3, 0);
        add_pkt(3, 2, 0);
        run_traffic(100, 100, 0);
        check("post_rst_npkts", 320'(ord_q.size()), 320'(2));
        check("post_rst_first", 320'(ord_q[0]), 320'(1));
        check("post_rst_second", 320'(ord_q[1]), 320'(3));

        // Randomized traffic: bursty sources, random sink
        for (int k = 0; k < 6; k++)
            for (int p = 0; p < N; p++) add_pkt(p, 1 + int'($urandom_range(5)), 0);
        run_traffic(3000, 75, 2);
        check("rand_npkts", 320'(ord_q.size()), 320'(6 * N));

        // Single-beat packets from ports 1 and 3 (tid observed when enabled)
        add_pkt(1, 1, 0);
        add_pkt(3, 1, 0);
        start_cyc[3] = 2;
        run_traffic(100, 100, 0);
        check("tid_npkts", 320'(ord_q.size()), 320'(2));
        check("tid_first", 320'(ord_q[0]), 320'(1));
        check("tid_second", 320'(ord_q[1]), 320'(3));

        repeat (3) @(negedge clk);
        check("final_idle", 320'({m_tvalid, busy}), 320'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
